// File: rtl/kmc_misc_pkg.sv
// Shared constants for the KMC11 MISC register: MISC bit positions,
// timer-control field positions and the timer mode type.
package kmc_misc_pkg;

  localparam int MISC_IRQ     = 7;
  localparam int MISC_VECT    = 6;
  localparam int MISC_LAT     = 5;
  localparam int MISC_TMR     = 4;
  localparam int MISC_BAEO_HI = 3;
  localparam int MISC_BAEO_LO = 2;
  localparam int MISC_ACLO    = 1;
  localparam int MISC_NXM     = 0;

  localparam int TCR_START  = 7;
  localparam int TCR_MODE   = 6;
  localparam int TCR_STOP   = 5;
  localparam int TCR_CLR    = 4;
  localparam int TCR_IDX_HI = 2;
  localparam int TCR_IDX_LO = 0;

  typedef enum logic {
    ONESHOT  = 1'b0,
    PERIODIC = 1'b1
  } tmode_t;

endpackage

// File: rtl/kmc_misc_timer.sv
// One programmable interval timer channel: down-counter, one-shot/periodic
// mode and a sticky expiry flag.
module kmc_misc_timer
  import kmc_misc_pkg::*;
#(
  parameter int              CNTW  = 12,
  parameter logic [CNTW-1:0] TICKS = CNTW'(5)
) (
  input  logic   clk,
  input  logic   rst,
  input  logic   start,
  input  tmode_t mode,
  input  logic   stop,
  input  logic   clr,
  output logic   done,
  output logic   texp
);

  logic [CNTW-1:0] count;
  tmode_t          mode_q;
  logic            last;
  logic            expire;

  assign last   = (count == CNTW'(1));
  // A stop issued on the final count cancels the expiry.
  assign expire = last & ~stop;
  assign done   = (count == '0);

  // Counter, mode and sticky expiry flag.
  always_ff @(posedge clk) begin
    if (rst) begin
      count  <= '0;
      mode_q <= ONESHOT;
      texp   <= 1'b0;
    end else begin
      if (stop) begin
        count <= '0;
      end else if (start) begin
        count  <= TICKS;
        mode_q <= mode;
      end else if (last) begin
        count <= (mode_q == PERIODIC) ? TICKS : '0;
      end else if (count != '0) begin
        count <= count - CNTW'(1);
      end else begin
        count <= count;
      end

      if (expire) begin
        texp <= 1'b1;
      end else if (clr) begin
        texp <= 1'b0;
      end else begin
        texp <= texp;
      end
    end
  end

endmodule

// File: rtl/kmc_misc_gen.sv
// KMC11 MISC register with a bank of interval timers and a held interrupt
// request, loaded from the ALU bus on MISC clock enables.
module kmc_misc_gen
  import kmc_misc_pkg::*;
#(
  parameter int CLKFRQ    = 50000000,
  parameter int NTIMER    = 2,
  parameter int PERIOD_US = 50,
  parameter int CNTW      = 12
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              kmcINIT,
  input  logic              kmcMISCCLKEN,
  input  logic              kmcLDMISC,
  input  logic              kmcLDTCR,
  input  logic [7:0]        kmcALU,
  input  logic              kmcSETNXM,
  input  logic              kmcIRQACK,
  output logic              kmcSETIRQ,
  output logic [7:0]        kmcMISC,
  output logic [NTIMER-1:0] kmcTDONE,
  output logic [NTIMER-1:0] kmcTEXP
);

  // 64-bit product: the default 50 us at 50 MHz overflows 32 bits.
  localparam longint          TICKS_L = longint'(PERIOD_US) * longint'(CLKFRQ) / 64'sd1000000;
  localparam logic [CNTW-1:0] TICKS   = CNTW'(TICKS_L);

  if (TICKS_L < 64'sd2 || TICKS_L >= (64'sd1 <<< CNTW)) begin : g_ticks_bad
    $error("kmc_misc_gen: TICKS must be >= 2 and fit in CNTW bits");
  end
  if (NTIMER < 1 || NTIMER > 8) begin : g_ntimer_bad
    $error("kmc_misc_gen: NTIMER must be 1..8");
  end

  logic       rst_all;
  logic       ld;
  logic       tc;
  logic [2:0] tc_idx;
  logic       irq;
  logic       vect;
  logic       lat;
  logic [1:0] baeo;
  logic       aclo;
  logic       nxm;

  assign rst_all = rst | kmcINIT;
  assign ld      = kmcMISCCLKEN & kmcLDMISC;
  assign tc      = kmcMISCCLKEN & kmcLDTCR;
  assign tc_idx  = kmcALU[TCR_IDX_HI:TCR_IDX_LO];

  assign kmcSETIRQ = ld & kmcALU[MISC_IRQ] & ~irq;
  assign kmcMISC   = {irq, vect, lat, kmcTDONE[0], baeo, aclo, nxm};

  // MISC bits and the held interrupt request.
  always_ff @(posedge clk) begin
    if (rst_all) begin
      irq  <= 1'b0;
      vect <= 1'b0;
      lat  <= 1'b0;
      baeo <= 2'b00;
      aclo <= 1'b0;
      nxm  <= 1'b0;
    end else begin
      if (ld) begin
        vect <= kmcALU[MISC_VECT];
        lat  <= kmcALU[MISC_LAT];
        baeo <= kmcALU[MISC_BAEO_HI:MISC_BAEO_LO];
        aclo <= kmcALU[MISC_ACLO];
      end else begin
        vect <= vect;
        lat  <= lat;
        baeo <= baeo;
        aclo <= aclo;
      end

      if (kmcSETNXM) begin
        nxm <= 1'b1;
      end else if (ld) begin
        nxm <= kmcALU[MISC_NXM];
      end else begin
        nxm <= nxm;
      end

      if (ld & kmcALU[MISC_IRQ]) begin
        irq <= 1'b1;
      end else if (kmcIRQACK) begin
        irq <= 1'b0;
      end else begin
        irq <= irq;
      end
    end
  end

  for (genvar i = 0; i < NTIMER; i++) begin : g_tmr
    logic   sel;
    logic   start;
    logic   stop;
    logic   clr;
    tmode_t mode;

    // A MISC load with bit 4 set is a one-shot start of timer 0 unless a TC owns the timers.
    assign sel   = tc & (tc_idx == 3'(i));
    assign start = sel ? kmcALU[TCR_START] : ((i == 0) & ~tc & ld & kmcALU[MISC_TMR]);
    assign stop  = sel & kmcALU[TCR_STOP];
    assign clr   = sel & kmcALU[TCR_CLR];
    assign mode  = (sel & kmcALU[TCR_MODE]) ? PERIODIC : ONESHOT;

    kmc_misc_timer #(
      .CNTW  (CNTW),
      .TICKS (TICKS)
    ) u_timer (
      .clk   (clk),
      .rst   (rst_all),
      .start (start),
      .mode  (mode),
      .stop  (stop),
      .clr   (clr),
      .done  (kmcTDONE[i]),
      .texp  (kmcTEXP[i])
    );
  end

endmodule

// File: tb/tb_kmc_misc_gen.sv
// Self-checking bench for kmc_misc_gen: directed scenarios from the timer/IRQ
// rules plus randomized traffic checked against a cycle-level reference model.
module tb_kmc_misc_gen;

  localparam int NT = 2;
  localparam int TK = 5;

  logic          clk = 1'b0;
  logic          rst, kmcINIT, kmcMISCCLKEN, kmcLDMISC, kmcLDTCR, kmcSETNXM, kmcIRQACK;
  logic [7:0]    kmcALU;
  logic          kmcSETIRQ;
  logic [7:0]    kmcMISC;
  logic [NT-1:0] kmcTDONE, kmcTEXP;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  kmc_misc_gen #(
    .CLKFRQ    (1000000),
    .NTIMER    (NT),
    .PERIOD_US (5),
    .CNTW      (4)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .kmcINIT      (kmcINIT),
    .kmcMISCCLKEN (kmcMISCCLKEN),
    .kmcLDMISC    (kmcLDMISC),
    .kmcLDTCR     (kmcLDTCR),
    .kmcALU       (kmcALU),
    .kmcSETNXM    (kmcSETNXM),
    .kmcIRQACK    (kmcIRQACK),
    .kmcSETIRQ    (kmcSETIRQ),
    .kmcMISC      (kmcMISC),
    .kmcTDONE     (kmcTDONE),
    .kmcTEXP      (kmcTEXP)
  );

  // Reference model: remaining cycles per timer, mode and flags.
  bit       m_irq, m_vect, m_lat, m_aclo, m_nxm;
  bit [1:0] m_baeo;
  int       m_cnt [NT];
  bit       m_per [NT];
  bit       m_texp[NT];

  function automatic logic [7:0] exp_misc();
    return {m_irq, m_vect, m_lat, (m_cnt[0] == 0), m_baeo, m_aclo, m_nxm};
  endfunction

  function automatic logic [NT-1:0] exp_tdone();
    logic [NT-1:0] r;
    for (int i = 0; i < NT; i++) r[i] = (m_cnt[i] == 0);
    return r;
  endfunction

  function automatic logic [NT-1:0] exp_texp();
    logic [NT-1:0] r;
    for (int i = 0; i < NT; i++) r[i] = m_texp[i];
    return r;
  endfunction

  task automatic clear_in();
    kmcMISCCLKEN = 1'b0; kmcLDMISC = 1'b0; kmcLDTCR = 1'b0;
    kmcALU = 8'h00; kmcSETNXM = 1'b0; kmcIRQACK = 1'b0;
  endtask

  // Advance the model by one clock with the current inputs, then clock the DUT.
  task automatic tick();
    bit ld, tc;
    int idx;
    ld  = kmcMISCCLKEN & kmcLDMISC;
    tc  = kmcMISCCLKEN & kmcLDTCR;
    idx = int'(kmcALU[2:0]);
    if (rst || kmcINIT) begin
      m_irq = 0; m_vect = 0; m_lat = 0; m_baeo = 2'b00; m_aclo = 0; m_nxm = 0;
      for (int i = 0; i < NT; i++) begin m_cnt[i] = 0; m_per[i] = 0; m_texp[i] = 0; end
    end else begin
      if (ld) begin
        m_vect = kmcALU[6]; m_lat = kmcALU[5]; m_baeo = kmcALU[3:2]; m_aclo = kmcALU[1];
      end
      if (kmcSETNXM) m_nxm = 1; else if (ld) m_nxm = kmcALU[0];
      if (ld && kmcALU[7]) m_irq = 1; else if (kmcIRQACK) m_irq = 0;
      for (int i = 0; i < NT; i++) begin
        bit st, sp, cl, md, hit;
        st = 0; sp = 0; cl = 0; md = 0;
        if (tc && idx == i) begin
          st = kmcALU[7]; md = kmcALU[6]; sp = kmcALU[5]; cl = kmcALU[4];
        end else if (!tc && ld && i == 0 && kmcALU[4]) begin
          st = 1;
        end
        hit = (m_cnt[i] == 1) && !sp;
        if (sp) m_cnt[i] = 0;
        else if (st) begin m_cnt[i] = TK; m_per[i] = md; end
        else if (m_cnt[i] == 1) m_cnt[i] = m_per[i] ? TK : 0;
        else if (m_cnt[i] > 0) m_cnt[i] = m_cnt[i] - 1;
        if (hit) m_texp[i] = 1; else if (cl) m_texp[i] = 0;
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; kmcINIT = 1'b0; clear_in();
    tick();
    rst = 1'b0;
    tick();
    tests++; if (kmcMISC !== 8'h10) begin fails++; $display("FAIL reset_misc: got %h expected %h", kmcMISC, 8'h10); end
    tests++; if (kmcTDONE !== 2'b11) begin fails++; $display("FAIL reset_tdone: got %b expected %b", kmcTDONE, 2'b11); end
    tests++; if (kmcTEXP !== 2'b00) begin fails++; $display("FAIL reset_texp: got %b expected %b", kmcTEXP, 2'b00); end
    tests++; if (kmcSETIRQ !== 1'b0) begin fails++; $display("FAIL reset_setirq: got %b expected 0", kmcSETIRQ); end
  endtask

  task automatic test_misc_load();
    kmcMISCCLKEN = 1'b1; kmcLDMISC = 1'b1; kmcALU = 8'h6E;
    tick(); clear_in();
    tests++; if (kmcMISC !== 8'h7E) begin fails++; $display("FAIL misc_load: got %h expected %h", kmcMISC, 8'h7E); end
    kmcMISCCLKEN = 1'b1; kmcLDMISC = 1'b1; kmcALU = 8'h00; kmcSETNXM = 1'b1;
    tick(); clear_in();
    tests++; if (kmcMISC !== 8'h11) begin fails++; $display("FAIL nxm_wins: got %h expected %h", kmcMISC, 8'h11); end
    kmcLDMISC = 1'b1; kmcALU = 8'h6E;
    tick(); clear_in();
    tests++; if (kmcMISC !== 8'h11) begin fails++; $display("FAIL ld_needs_clken: got %h expected %h", kmcMISC, 8'h11); end
  endtask

  task automatic test_oneshot();
    int low;
    low = 0;
    for (int k = 1; k <= 12; k++) begin
      if (k == 1) begin kmcMISCCLKEN = 1'b1; kmcLDTCR = 1'b1; kmcALU = 8'h80; end
      tick(); clear_in();
      if (kmcTDONE[0] == 1'b0) low++;
    end
    tests++; if (low != TK) begin fails++; $display("FAIL oneshot_low: got %0d cycles expected %0d", low, TK); end
    tests++; if (kmcTEXP[0] !== 1'b1) begin fails++; $display("FAIL oneshot_texp: got %b expected 1", kmcTEXP[0]); end
    low = 0;
    for (int k = 1; k <= 15; k++) begin
      if (k == 1) begin kmcMISCCLKEN = 1'b1; kmcLDTCR = 1'b1; kmcALU = 8'h90; end
      if (k == 4) begin kmcMISCCLKEN = 1'b1; kmcLDTCR = 1'b1; kmcALU = 8'h80; end
      tick(); clear_in();
      if (kmcTDONE[0] == 1'b0) low++;
      if (k == 1) begin
        tests++; if (kmcTEXP[0] !== 1'b0) begin fails++; $display("FAIL start_clr_texp: got %b expected 0", kmcTEXP[0]); end
      end
    end
    tests++; if (low != 8) begin fails++; $display("FAIL retrigger_low: got %0d cycles expected 8", low); end
    tests++; if (kmcMISC[4] !== 1'b1 || kmcTEXP[0] !== 1'b1) begin fails++; $display("FAIL retrigger_end: got tmr=%b texp=%b expected 1 1", kmcMISC[4], kmcTEXP[0]); end
  endtask

  task automatic test_periodic();
    bit want;
    for (int k = 0; k <= 12; k++) begin
      if (k == 0) begin kmcMISCCLKEN = 1'b1; kmcLDTCR = 1'b1; kmcALU = 8'hC1; end
      if (k == 7) begin kmcMISCCLKEN = 1'b1; kmcLDTCR = 1'b1; kmcALU = 8'h11; end
      tick(); clear_in();
      want = (k >= 5 && k < 7) || (k >= 10);
      tests++; if (kmcTEXP[1] !== want) begin fails++; $display("FAIL periodic_texp k=%0d: got %b expected %b", k, kmcTEXP[1], want); end
      tests++; if (kmcTDONE[1] !== 1'b0) begin fails++; $display("FAIL periodic_tdone k=%0d: got %b expected 0", k, kmcTDONE[1]); end
    end
    kmcMISCCLKEN = 1'b1; kmcLDTCR = 1'b1; kmcALU = 8'h31;
    tick(); clear_in();
    tests++; if (kmcTDONE[1] !== 1'b1 || kmcTEXP[1] !== 1'b0) begin fails++; $display("FAIL stop: got done=%b texp=%b expected 1 0", kmcTDONE[1], kmcTEXP[1]); end
    for (int k = 0; k < 12; k++) tick();
    tests++; if (kmcTEXP !== 2'b01 || kmcTDONE !== 2'b11) begin fails++; $display("FAIL after_stop: got texp=%b done=%b expected 01 11", kmcTEXP, kmcTDONE); end
    kmcMISCCLKEN = 1'b1; kmcLDTCR = 1'b1; kmcALU = 8'hC5;
    tick(); clear_in();
    tests++; if (kmcTDONE !== 2'b11 || kmcTEXP !== 2'b01) begin fails++; $display("FAIL bad_index: got done=%b texp=%b expected 11 01", kmcTDONE, kmcTEXP); end
  endtask

  task automatic test_irq();
    kmcMISCCLKEN = 1'b1; kmcLDMISC = 1'b1; kmcALU = 8'h80;
    #1;
    tests++; if (kmcSETIRQ !== 1'b1) begin fails++; $display("FAIL setirq_pulse: got %b expected 1", kmcSETIRQ); end
    tick(); clear_in();
    #1;
    tests++; if (kmcSETIRQ !== 1'b0 || kmcMISC[7] !== 1'b1) begin fails++; $display("FAIL irq_held: got setirq=%b irq=%b expected 0 1", kmcSETIRQ, kmcMISC[7]); end
    kmcMISCCLKEN = 1'b1; kmcLDMISC = 1'b1; kmcALU = 8'h80;
    #1;
    tests++; if (kmcSETIRQ !== 1'b0) begin fails++; $display("FAIL setirq_pending: got %b expected 0", kmcSETIRQ); end
    tick(); clear_in();
    kmcIRQACK = 1'b1;
    tick(); clear_in();
    tests++; if (kmcMISC[7] !== 1'b0) begin fails++; $display("FAIL irq_ack: got %b expected 0", kmcMISC[7]); end
    kmcMISCCLKEN = 1'b1; kmcLDMISC = 1'b1; kmcALU = 8'h80; kmcIRQACK = 1'b1;
    #1;
    tests++; if (kmcSETIRQ !== 1'b1) begin fails++; $display("FAIL setirq_with_ack: got %b expected 1", kmcSETIRQ); end
    tick(); clear_in();
    tests++; if (kmcMISC[7] !== 1'b1) begin fails++; $display("FAIL set_beats_ack: got %b expected 1", kmcMISC[7]); end
    kmcIRQACK = 1'b1;
    tick(); clear_in();
  endtask

  task automatic test_init();
    kmcMISCCLKEN = 1'b1; kmcLDTCR = 1'b1; kmcALU = 8'hC1;
    tick(); clear_in();
    tick(); tick();
    kmcINIT = 1'b1;
    tick();
    kmcINIT = 1'b0;
    tests++; if (kmcTDONE !== 2'b11 || kmcTEXP !== 2'b00) begin fails++; $display("FAIL init_abort: got done=%b texp=%b expected 11 00", kmcTDONE, kmcTEXP); end
    tests++; if (kmcMISC !== 8'h10) begin fails++; $display("FAIL init_misc: got %h expected %h", kmcMISC, 8'h10); end
    for (int k = 0; k < 10; k++) tick();
    tests++; if (kmcTEXP !== 2'b00 || kmcTDONE !== 2'b11) begin fails++; $display("FAIL init_no_expiry: got texp=%b done=%b expected 00 11", kmcTEXP, kmcTDONE); end
  endtask

  task automatic test_random();
    logic want_irq;
    for (int k = 0; k < 400; k++) begin
      rst          = ($urandom_range(0, 99) == 0);
      kmcINIT      = ($urandom_range(0, 99) == 0);
      kmcMISCCLKEN = ($urandom_range(0, 3) != 0);
      kmcLDMISC    = ($urandom_range(0, 4) == 0);
      kmcLDTCR     = ($urandom_range(0, 2) == 0);
      kmcALU       = 8'($urandom);
      if (kmcLDTCR && $urandom_range(0, 3) != 0) kmcALU[2:0] = 3'($urandom_range(0, NT - 1));
      kmcSETNXM    = ($urandom_range(0, 7) == 0);
      kmcIRQACK    = ($urandom_range(0, 3) == 0);
      #1;
      want_irq = kmcMISCCLKEN & kmcLDMISC & kmcALU[7] & ~m_irq;
      tests++; if (kmcSETIRQ !== want_irq) begin fails++; $display("FAIL rnd_setirq k=%0d: got %b expected %b", k, kmcSETIRQ, want_irq); end
      tick();
      tests++; if (kmcMISC !== exp_misc()) begin fails++; $display("FAIL rnd_misc k=%0d: got %h expected %h", k, kmcMISC, exp_misc()); end
      tests++; if (kmcTDONE !== exp_tdone()) begin fails++; $display("FAIL rnd_tdone k=%0d: got %b expected %b", k, kmcTDONE, exp_tdone()); end
      tests++; if (kmcTEXP !== exp_texp()) begin fails++; $display("FAIL rnd_texp k=%0d: got %b expected %b", k, kmcTEXP, exp_texp()); end
    end
    rst = 1'b0; kmcINIT = 1'b0; clear_in();
  endtask

  initial begin
    test_reset();
    test_misc_load();
    test_oneshot();
    test_periodic();
    test_irq();
    test_init();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
